data_cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the core's load/store path and word-wide data memory.
- Services the memory requests raised by instruction decode: lw, sw, lh and sh.
- Stalls the core on misses and writes, and refills 4-word blocks from memory over a ready handshake.

---
 rtl/data_cache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word block refill.
// Optional feature macro: DCACHE_STATS_EN (saturating read hit/miss counters).
module data_cache_ctrl #(
  parameter int INDEX_W     = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_read,
  input  logic              core_write,
  input  logic              core_half,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - 4 - INDEX_W;
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES][BLOCK_WORDS];
  logic [OFF_W-1:0]    cnt_q;
  logic [TAG_W-1:0]    refill_tag_q;
  logic [INDEX_W-1:0]  refill_idx_q;
  logic                refill_done_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [3:0]          mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic [TAG_W-1:0]    tag_w;
  logic [INDEX_W-1:0]  idx_w;
  logic [OFF_W-1:0]    word_w;
  logic                hit_w;
  logic [31:0]         rd_word_w;
  logic [15:0]         rd_half_w;
  logic                unused_addr0;

  assign tag_w        = core_addr[ADDR_W-1:4+INDEX_W];
  assign idx_w        = core_addr[3+INDEX_W:4];
  assign word_w       = core_addr[3:2];
  assign unused_addr0 = core_addr[0];
  assign hit_w        = valid_q[idx_w] && (tag_q[idx_w] == tag_w);
  assign rd_word_w    = data_q[idx_w][word_w];
  assign rd_half_w    = core_addr[1] ? rd_word_w[31:16] : rd_word_w[15:0];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Hits return data in the same cycle; a store retires in the cycle its memory write completes.
  always_comb begin
    core_stall = 1'b0;
    core_rdata = '0;
    case (state_q)
      IDLE: begin
        core_stall = core_write | (core_read & ~hit_w);
        if (core_read && !core_write && hit_w)
          core_rdata = core_half ? {{16{rd_half_w[15]}}, rd_half_w} : rd_word_w;
      end
      REFILL:  core_stall = 1'b1;
      WRITE:   core_stall = ~mem_ready;
      default: core_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      cnt_q         <= '0;
      refill_tag_q  <= '0;
      refill_idx_q  <= '0;
      refill_done_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          refill_done_q <= 1'b0;
          if (core_write) begin
            state_q    <= WRITE;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= {core_addr[ADDR_W-1:2], 2'b00};
            if (core_half) begin
              mem_be_q    <= core_addr[1] ? 4'b1100 : 4'b0011;
              mem_wdata_q <= {2{core_wdata[15:0]}};
            end else begin
              mem_be_q    <= 4'b1111;
              mem_wdata_q <= core_wdata;
            end
          end else if (core_read && !hit_w) begin
            state_q      <= REFILL;
            cnt_q        <= '0;
            refill_tag_q <= tag_w;
            refill_idx_q <= idx_w;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= {tag_w, idx_w, 4'b0000};
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            if (cnt_q == OFF_W'(BLOCK_WORDS - 1)) begin
              valid_q[refill_idx_q] <= 1'b1;
              refill_done_q         <= 1'b1;
              state_q               <= IDLE;
              mem_req_q             <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_ready) begin
      data_q[refill_idx_q][cnt_q] <= mem_rdata;
      if (cnt_q == OFF_W'(BLOCK_WORDS - 1))
        tag_q[refill_idx_q] <= refill_tag_q;
    end
    if (state_q == WRITE && mem_ready && hit_w) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_q[b])
          data_q[idx_w][word_w][8*b +: 8] <= mem_wdata_q[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // The hit seen right after a refill is the same load retiring, so it is not counted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && core_read && !core_write) begin
      if (hit_w) begin
        if (!refill_done_q && hit_cnt_q != 16'hFFFF)
          hit_cnt_q <= hit_cnt_q + 16'd1;
      end else if (miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_refill_done;
  assign unused_refill_done = refill_done_q;
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: vector table plus hand sequences for
// the long write wait and reset in the middle of a refill.
module tb_data_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_read, core_write, core_half;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int expHits = 0;
  int expMisses = 0;

  // Memory model state shared with the responder
  logic [31:0] memModel [512];
  int          readyDelay = 1;
  int          waitCnt = 0;
  int          readCount = 0;
  int          writeCount = 0;
  logic [31:0] readAddrs [$];
  logic [31:0] lastWrAddr, lastWrData;
  logic [3:0]  lastWrBe;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          half;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    int          expStall;
    int          expReads;
    logic [3:0]  expBe;
    logic [31:0] expWrAddr;
    logic [31:0] expWrData;
  } vec_t;

  vec_t vecs [17];

  data_cache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_read  (core_read),
    .core_write (core_write),
    .core_half  (core_half),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Word memory: raises mem_ready readyDelay+1 cycles after each request word
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 512; i++) memModel[i] = 32'h1000 + i;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && rst_n) begin
        if (waitCnt >= readyDelay) begin
          mem_ready = 1'b1;
          waitCnt = 0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) memModel[mem_addr[10:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            lastWrAddr = mem_addr;
            lastWrBe   = mem_be;
            lastWrData = mem_wdata;
            writeCount++;
          end else begin
            mem_rdata = memModel[mem_addr[10:2]];
            readAddrs.push_back(mem_addr);
            readCount++;
          end
        end else begin
          mem_ready = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ready = 1'b0;
        waitCnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkRead(input logic [31:0] addr, input bit half, input logic [31:0] expRdata,
                                  input int expStall, input int expReads);
    vec_t v;
    v.rd = 1'b1; v.wr = 1'b0; v.half = half; v.addr = addr; v.wdata = '0;
    v.expRdata = expRdata; v.expStall = expStall; v.expReads = expReads;
    v.expBe = '0; v.expWrAddr = '0; v.expWrData = '0;
    return v;
  endfunction

  function automatic vec_t mkWrite(input logic [31:0] addr, input bit half, input logic [31:0] wdata,
                                   input bit alsoRead, input logic [3:0] expBe,
                                   input logic [31:0] expWrAddr, input logic [31:0] expWrData);
    vec_t v;
    v.rd = alsoRead; v.wr = 1'b1; v.half = half; v.addr = addr; v.wdata = wdata;
    v.expRdata = '0; v.expStall = 2; v.expReads = 0;
    v.expBe = expBe; v.expWrAddr = expWrAddr; v.expWrData = expWrData;
    return v;
  endfunction

  // Drives one request and holds it until core_stall drops, then retires it
  task automatic applyStimulus(input vec_t v, output logic [31:0] rdata, output int stallCycles,
                               output bit timedOut);
    bit done = 1'b0;
    @(negedge clk);
    readAddrs.delete();
    readCount  = 0;
    writeCount = 0;
    core_read  = v.rd;
    core_write = v.wr;
    core_half  = v.half;
    core_addr  = v.addr;
    core_wdata = v.wdata;
    stallCycles = 0;
    rdata = '0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!core_stall) begin
        rdata = core_rdata;
        done = 1'b1;
        break;
      end
      stallCycles++;
      @(negedge clk);
    end
    timedOut = !done;
    @(posedge clk);
    #1;
    core_read  = 1'b0;
    core_write = 1'b0;
    core_half  = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    logic [31:0] rdata;
    int          stallCycles;
    bit          timedOut;
    logic [31:0] base;
    applyStimulus(v, rdata, stallCycles, timedOut);
    if (timedOut) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: core_stall still 1 after 200 cycles", tag);
      return;
    end
    checkOutput({tag, " rdata"}, rdata, v.expRdata);
    checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(v.expStall));
    checkOutput({tag, " mem reads"}, 32'(readCount), 32'(v.expReads));
    base = v.addr & 32'hFFFF_FFF0;
    for (int i = 0; i < readAddrs.size() && i < 4; i++)
      checkOutput($sformatf("%s refill addr%0d", tag, i), readAddrs[i], base + 32'(4 * i));
    if (v.wr) begin
      checkOutput({tag, " mem writes"}, 32'(writeCount), 32'd1);
      checkOutput({tag, " mem_be"}, {28'd0, lastWrBe}, {28'd0, v.expBe});
      checkOutput({tag, " mem_addr"}, lastWrAddr, v.expWrAddr);
      checkOutput({tag, " mem_wdata"}, lastWrData, v.expWrData);
    end else if (v.expReads == 0) begin
      expHits++;
    end else begin
      expMisses++;
    end
  endtask

  task automatic checkStats(input string tag);
`ifdef DCACHE_STATS_EN
    checkOutput({tag, " hit_cnt"}, {16'd0, hit_cnt}, 32'(expHits));
    checkOutput({tag, " miss_cnt"}, {16'd0, miss_cnt}, 32'(expMisses));
`else
    checkOutput({tag, " hit_cnt"}, {16'd0, hit_cnt}, 32'd0);
    checkOutput({tag, " miss_cnt"}, {16'd0, miss_cnt}, 32'd0);
`endif
  endtask

  initial begin
    int  stallCycles;
    int  waitCycles;
    bit  done;

    // Memory word i holds 0x1000+i; a miss with readyDelay=1 stalls 1 + 4*2 cycles
    vecs[0]  = mkRead(32'h40,  1'b0, 32'h0000_1010, 9, 4);
    vecs[1]  = mkRead(32'h44,  1'b0, 32'h0000_1011, 0, 0);
    vecs[2]  = mkWrite(32'h42, 1'b1, 32'h0000_BEEF, 1'b0, 4'b1100, 32'h40, 32'hBEEF_BEEF);
    vecs[3]  = mkRead(32'h42,  1'b1, 32'hFFFF_BEEF, 0, 0);
    vecs[4]  = mkRead(32'h40,  1'b1, 32'h0000_1010, 0, 0);
    vecs[5]  = mkWrite(32'h200, 1'b0, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h200, 32'hCAFE_F00D);
    vecs[6]  = mkRead(32'h200, 1'b0, 32'hCAFE_F00D, 9, 4);
    vecs[7]  = mkRead(32'h440, 1'b0, 32'h0000_1110, 9, 4);
    vecs[8]  = mkRead(32'h40,  1'b0, 32'hBEEF_1010, 9, 4);
    vecs[9]  = mkRead(32'h4C,  1'b0, 32'h0000_1013, 0, 0);
    vecs[10] = mkWrite(32'h48, 1'b0, 32'h8000_1234, 1'b1, 4'b1111, 32'h48, 32'h8000_1234);
    vecs[11] = mkRead(32'h4A,  1'b1, 32'hFFFF_8000, 0, 0);
    vecs[12] = mkRead(32'h49,  1'b1, 32'h0000_1234, 0, 0);
    vecs[13] = mkWrite(32'h4D, 1'b1, 32'h1234_7FFF, 1'b0, 4'b0011, 32'h4C, 32'h7FFF_7FFF);
    vecs[14] = mkRead(32'h4C,  1'b0, 32'h0000_7FFF, 0, 0);
    vecs[15] = mkRead(32'h204, 1'b0, 32'h0000_1081, 0, 0);
    vecs[16] = mkRead(32'h440, 1'b0, 32'h0000_1110, 9, 4);

    rst_n = 1'b0;
    core_read = 1'b0; core_write = 1'b0; core_half = 1'b0;
    core_addr = '0; core_wdata = '0;
    #12;
    checkOutput("reset core_stall", {31'd0, core_stall}, 32'd0);
    checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset core_rdata", core_rdata, 32'd0);
    checkStats("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) runVec(vecs[i], $sformatf("vec%0d", i));
    checkStats("after table");

    // Long memory wait on a store: request fields must hold steady until mem_ready
    readyDelay = 5;
    @(negedge clk);
    writeCount = 0;
    core_write = 1'b1; core_half = 1'b0; core_addr = 32'h44; core_wdata = 32'h55AA_55AA;
    stallCycles = 0; waitCycles = 0; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!core_stall) begin
        done = 1'b1;
        break;
      end
      stallCycles++;
      if (mem_req && !mem_ready) begin
        waitCycles++;
        checkOutput($sformatf("wait%0d mem_addr", waitCycles), mem_addr, 32'h44);
        checkOutput($sformatf("wait%0d mem_be", waitCycles), {28'd0, mem_be}, 32'hF);
        checkOutput($sformatf("wait%0d mem_we", waitCycles), {31'd0, mem_we}, 32'd1);
        checkOutput($sformatf("wait%0d mem_wdata", waitCycles), mem_wdata, 32'h55AA_55AA);
      end
      @(negedge clk);
    end
    checkOutput("long write done", {31'd0, done}, 32'd1);
    checkOutput("long write stall cycles", 32'(stallCycles), 32'd6);
    checkOutput("long write wait cycles", 32'(waitCycles), 32'd5);
    @(posedge clk);
    #1;
    core_write = 1'b0;
    readyDelay = 1;
    #2;
    checkOutput("long write count", 32'(writeCount), 32'd1);

    // Reset right after the second refill word lands
    @(negedge clk);
    readCount = 0;
    core_read = 1'b1; core_half = 1'b0; core_addr = 32'h300;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #3;
      if (readCount == 2) break;
    end
    checkOutput("mid-refill read count", 32'(readCount), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-refill reset mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mid-refill reset mem_addr", mem_addr, 32'd0);
    expHits = 0;
    expMisses = 0;
    checkStats("mid-refill reset");
    @(negedge clk);
    core_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runVec(mkRead(32'h300, 1'b0, 32'h0000_10C0, 9, 4), "post-reset lw 0x300");
    runVec(mkRead(32'h40,  1'b0, 32'hBEEF_1010, 9, 4), "post-reset lw 0x40");
    runVec(mkRead(32'h304, 1'b0, 32'h0000_10C1, 0, 0), "post-reset lw 0x304");
    checkStats("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
